// File: rtl/parallel_to_serial_converter_pkg.sv
// Shared types and constants for the parallel-to-serial transmitter.
// Holds the FSM state encoding and the idle line level.
package parallel_to_serial_converter_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  localparam logic IdleLevel = 1'b0;

endpackage

// File: rtl/piso_shift_register.sv
// Shift register and bit counter for the parallel-to-serial transmitter.
// The top decides when to load, shift or clear; priority is load > shift > clear.
module piso_shift_register #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_en,
  input  logic [DATA_WIDTH-1:0]         load_word,
  input  logic                          shift_en,
  input  logic                          clear_en,
  output logic                          serial_bit,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_cnt,
  output logic                          last_bit
);

  localparam int unsigned CntWidth = $clog2(DATA_WIDTH);
  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sh_reg_q;
  logic [CntWidth-1:0]   bit_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_reg_q  <= '0;
      bit_cnt_q <= '0;
    end else if (load_en) begin
      sh_reg_q  <= load_word;
      bit_cnt_q <= '0;
    end else if (shift_en) begin
      sh_reg_q  <= sh_reg_q >> 1;
      bit_cnt_q <= bit_cnt_q + CntWidth'(1);
    end else if (clear_en) begin
      sh_reg_q  <= '0;
      bit_cnt_q <= '0;
    end
  end

  assign serial_bit = sh_reg_q[0];
  assign bit_cnt    = bit_cnt_q;
  assign last_bit   = (bit_cnt_q == LastIdx);

endmodule

// File: rtl/parallel_to_serial_converter.sv
// LSB-first serialiser with valid/ready load and a one-word holding register,
// so a word held or accepted on the last bit follows with no idle cycle.
module parallel_to_serial_converter
  import parallel_to_serial_converter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] parallelDataIn,
  input  logic                  loadValid,
  output logic                  loadReady,
  output logic                  serialDataOut,
  output logic                  frameStart,
  output logic                  busy
);

  localparam int unsigned CntWidth = $clog2(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_full_q, hold_full_d;

  logic                  accept;
  logic                  load_en;
  logic [DATA_WIDTH-1:0] load_word;
  logic                  shift_en;
  logic                  clear_en;
  logic                  sr_bit;
  logic [CntWidth-1:0]   bit_cnt;
  logic                  last_bit;

  assign accept = loadValid && !hold_full_q;

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    load_en     = 1'b0;
    load_word   = parallelDataIn;
    shift_en    = 1'b0;
    clear_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          load_en = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (last_bit) begin
          if (hold_full_q) begin
            // Held word takes priority; accept is impossible while it is full.
            load_en     = 1'b1;
            load_word   = hold_data_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            load_en = 1'b1;
          end else begin
            clear_en = 1'b1;
            state_d  = StIdle;
          end
        end else begin
          shift_en = 1'b1;
          if (accept) begin
            hold_data_d = parallelDataIn;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
    end
  end

  piso_shift_register #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_word (load_word),
    .shift_en  (shift_en),
    .clear_en  (clear_en),
    .serial_bit(sr_bit),
    .bit_cnt   (bit_cnt),
    .last_bit  (last_bit)
  );

  assign loadReady     = !hold_full_q;
  assign busy          = (state_q == StShift);
  assign frameStart    = (state_q == StShift) && (bit_cnt == '0);
  assign serialDataOut = (state_q == StShift) ? sr_bit : IdleLevel;

endmodule

// File: tb/tb_parallel_to_serial_converter.sv
// Directed bench for the parallel-to-serial transmitter at widths 8 and 4.
module tb_parallel_to_serial_converter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data8;
  logic       valid8;
  logic       ready8, ser8, fs8, busy8;
  logic [3:0] data4;
  logic       valid4;
  logic       ready4, ser4, fs4, busy4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  parallel_to_serial_converter #(
    .DATA_WIDTH(8)
  ) dut8 (
    .clk           (clk),
    .reset         (reset),
    .parallelDataIn(data8),
    .loadValid     (valid8),
    .loadReady     (ready8),
    .serialDataOut (ser8),
    .frameStart    (fs8),
    .busy          (busy8)
  );

  parallel_to_serial_converter #(
    .DATA_WIDTH(4)
  ) dut4 (
    .clk           (clk),
    .reset         (reset),
    .parallelDataIn(data4),
    .loadValid     (valid4),
    .loadReady     (ready4),
    .serialDataOut (ser4),
    .frameStart    (fs4),
    .busy          (busy4)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle8(input string tag);
    check_val({tag, " busy"}, busy8, 1'b0);
    check_val({tag, " ser"}, ser8, 1'b0);
    check_val({tag, " fs"}, fs8, 1'b0);
    check_val({tag, " ready"}, ready8, 1'b1);
  endtask

  logic [7:0]  w;
  logic [15:0] two;
  logic [23:0] three;
  logic [3:0]  w4;

  initial begin
    reset  = 1'b1;
    data8  = '0;
    valid8 = 1'b0;
    data4  = '0;
    valid4 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_idle8("reset");
    check_val("reset ready4", ready4, 1'b1);
    check_val("reset busy4", busy4, 1'b0);

    // Single word 0xA5 from idle.
    w = 8'hA5;
    data8 = w; valid8 = 1'b1;
    tick();
    valid8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_val("a5 ser", ser8, w[k]);
      check_val("a5 fs", fs8, k == 0);
      check_val("a5 busy", busy8, 1'b1);
      tick();
    end
    check_idle8("a5 end");

    // 0x01 then 0xFF accepted mid-frame into the holding register.
    two = 16'hFF01;
    data8 = 8'h01; valid8 = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      if (c == 1) data8 = 8'hFF;
      if (c == 2) valid8 = 1'b0;
      check_val("b2b ser", ser8, two[c-1]);
      check_val("b2b fs", fs8, (c == 1) || (c == 9));
      check_val("b2b busy", busy8, 1'b1);
      check_val("b2b ready", ready8, (c == 1) || (c >= 9));
      tick();
    end
    check_idle8("b2b end");

    // Valid held high with 0x3C while the holding register is full.
    three = 24'h3CAA0F;
    data8 = 8'h0F; valid8 = 1'b1;
    tick();
    for (int c = 1; c <= 24; c++) begin
      if (c == 1) data8 = 8'hAA;
      if (c == 2) data8 = 8'h3C;
      if (c == 10) valid8 = 1'b0;
      check_val("hold ser", ser8, three[c-1]);
      check_val("hold fs", fs8, ((c - 1) % 8) == 0);
      check_val("hold busy", busy8, 1'b1);
      check_val("hold ready", ready8, (c == 1) || (c == 9) || (c >= 17));
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      check_idle8("hold end");
      tick();
    end

    // Word accepted exactly on the last bit with the holding register empty.
    two = 16'h6E81;
    data8 = 8'h81; valid8 = 1'b1;
    tick();
    valid8 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 8) begin
        data8 = 8'h6E; valid8 = 1'b1;
      end
      if (c == 9) valid8 = 1'b0;
      check_val("last ser", ser8, two[c-1]);
      check_val("last fs", fs8, (c == 1) || (c == 9));
      check_val("last busy", busy8, 1'b1);
      check_val("last ready", ready8, 1'b1);
      tick();
    end
    check_idle8("last end");

    // Reset on bit 3 of 0xC3 with 0x55 held.
    w = 8'hC3;
    data8 = w; valid8 = 1'b1;
    tick();
    data8 = 8'h55;
    check_val("rst bit0", ser8, w[0]);
    tick();
    valid8 = 1'b0;
    check_val("rst held ready", ready8, 1'b0);
    tick();
    tick();
    check_val("rst bit3", ser8, w[3]);
    reset = 1'b1;
    tick();
    check_idle8("rst after");
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      check_idle8("rst quiet");
    end

    // Width 4, back-to-back 0x9 with valid held.
    w4 = 4'h9;
    data4 = w4; valid4 = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      if (c == 13) valid4 = 1'b0;
      check_val("w4 ser", ser4, w4[(c-1)%4]);
      check_val("w4 fs", fs4, ((c - 1) % 4) == 0);
      check_val("w4 busy", busy4, 1'b1);
      tick();
    end
    check_val("w4 end busy", busy4, 1'b0);
    check_val("w4 end ser", ser4, 1'b0);
    check_val("w4 end ready", ready4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
